// File: rtl/bfxp_pkg.sv
// Shared types and helpers for the bit-field extract/place arbiter slice.
// Holds the operation/result structs and the field-mask helper.
package bfxp_pkg;

  localparam int XLEN     = 32;
  localparam int SHW      = 5;
  localparam int ID_MAX_W = 2;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [SHW-1:0]  start;
    logic [SHW-1:0]  len;
    logic [SHW-1:0]  dest;
    logic            bfxpc;
  } bfxp_op_t;

  typedef struct packed {
    logic [XLEN-1:0]     data;
    logic [ID_MAX_W-1:0] id;
  } bfxp_res_t;

  // Bits dest..min(dest+len-1, 31); an empty field yields an all-zero mask.
  function automatic logic [XLEN-1:0] field_mask(input logic [SHW-1:0] dest,
                                                 input logic [SHW-1:0] len);
    logic [SHW:0] hi;
    logic [XLEN-1:0] lo_m;
    logic [XLEN-1:0] hi_m;
    hi = {1'b0, dest} + {1'b0, len} - 6'd1;
    if (hi > 6'd31) begin
      hi = 6'd31;
    end else begin
      hi = hi;
    end
    lo_m = {XLEN{1'b1}} << dest;
    hi_m = {XLEN{1'b1}} >> (5'd31 - hi[SHW-1:0]);
    if (len == 5'd0) begin
      return {XLEN{1'b0}};
    end else begin
      return lo_m & hi_m;
    end
  endfunction

endpackage

// File: rtl/bfxp_dp.sv
// Single-cycle bit-field extract/place datapath with a registered result.
// The result register carries no reset; consumers must qualify it.
module bfxp_dp
  import bfxp_pkg::*;
(
  input  logic            clock,
  input  bfxp_op_t        op,
  output logic [XLEN-1:0] result
);

  logic [SHW-1:0]  amt_s;
  logic [XLEN-1:0] rot_s;
  logic [XLEN-1:0] mask_s;
  logic [XLEN-1:0] res_s;

  // Rotate source into place, then merge the field over the background word.
  always_comb begin
    amt_s  = op.start - op.dest;
    rot_s  = XLEN'({op.rs1, op.rs1} >> amt_s);
    mask_s = field_mask(op.dest, op.len);
    res_s  = ((rot_s ^ {XLEN{op.bfxpc}}) & mask_s) | (op.rs2 & ~mask_s);
  end

  // Result register.
  always_ff @(posedge clock) begin
    result <= res_s;
  end

endmodule

// File: rtl/bfxp_rr_arb.sv
// Parameterised round-robin grant; the pointer names the highest-priority
// requester and advances past the winner only when en is high.
module bfxp_rr_arb #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] ptr_r;
  logic [N-1:0]   req_rot_s;
  logic [N-1:0]   gnt_rot_s;
  logic [IDW-1:0] off_s;
  logic           found_s;
  logic [IDW:0]   sum_s;
  logic [IDW:0]   nxt_s;

  // Rotate requests so the pointer sits at bit 0, pick the lowest, rotate back.
  always_comb begin
    req_rot_s = N'({req, req} >> ptr_r);
    gnt_rot_s = '0;
    off_s     = '0;
    found_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found_s && req_rot_s[k]) begin
        gnt_rot_s[k] = 1'b1;
        off_s        = IDW'(k);
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    grant = N'(({gnt_rot_s, gnt_rot_s} << ptr_r) >> N);
    sum_s = {1'b0, ptr_r} + {1'b0, off_s};
    if (sum_s >= (IDW+1)'(N)) begin
      sum_s = sum_s - (IDW+1)'(N);
    end else begin
      sum_s = sum_s;
    end
    grant_id = sum_s[IDW-1:0];
    nxt_s    = {1'b0, grant_id} + (IDW+1)'(1);
    if (nxt_s == (IDW+1)'(N)) begin
      nxt_s = '0;
    end else begin
      nxt_s = nxt_s;
    end
  end

  // Priority pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (en) begin
      ptr_r <= nxt_s[IDW-1:0];
    end
  end

endmodule

// File: rtl/bfxp_arbiter.sv
// Shares one bfxp datapath between NREQ requesters: round-robin issue,
// one-cycle datapath, 2-entry in-order result FIFO tagged with requester id.
module bfxp_arbiter
  import bfxp_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_rs1,
  input  logic [32*NREQ-1:0]   req_rs2,
  input  logic [5*NREQ-1:0]    req_start,
  input  logic [5*NREQ-1:0]    req_len,
  input  logic [5*NREQ-1:0]    req_dest,
  input  logic [NREQ-1:0]      req_bfxpc,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic                 busy
);

  bfxp_op_t        ops_s [NREQ];
  bfxp_op_t        op_s;
  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_id_s;
  logic            issue_allowed_s;
  logic            issue_s;
  logic            pop_s;
  logic            push_s;
  logic [2:0]      occ_s;
  logic [XLEN-1:0] dp_result_s;
  bfxp_res_t       push_entry_s;
  bfxp_res_t       head_s;

  logic            inflight_r;
  logic [IDW-1:0]  id_r;
  bfxp_res_t       fifo_mem_r [2];
  logic            rd_ptr_r;
  logic            wr_ptr_r;
  logic [1:0]      count_r;

  for (genvar i = 0; i < NREQ; i++) begin : g_ops
    assign ops_s[i] = '{rs1:   req_rs1[32*i +: 32],
                        rs2:   req_rs2[32*i +: 32],
                        start: req_start[5*i +: 5],
                        len:   req_len[5*i +: 5],
                        dest:  req_dest[5*i +: 5],
                        bfxpc: req_bfxpc[i]};
  end

  bfxp_rr_arb #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .clock    (clock),
    .reset    (reset),
    .req      (req_valid),
    .en       (issue_s),
    .grant    (grant_s),
    .grant_id (grant_id_s)
  );

  bfxp_dp u_dp (
    .clock  (clock),
    .op     (op_s),
    .result (dp_result_s)
  );

  // Issue control: at most two results may be owed (in flight plus queued).
  always_comb begin
    pop_s           = resp_valid & resp_ready;
    push_s          = inflight_r;
    occ_s           = {1'b0, count_r} + {2'b00, inflight_r};
    issue_allowed_s = ((occ_s - {2'b00, pop_s}) < 3'd2) & ~reset;
    req_ready       = grant_s & {NREQ{issue_allowed_s}};
    issue_s         = |(req_valid & req_ready);
    op_s            = ops_s[grant_id_s];
    push_entry_s    = '{data: dp_result_s, id: ID_MAX_W'(id_r)};
    head_s          = fifo_mem_r[rd_ptr_r];
  end

  // Launch tracking; only a tracked launch may be captured from the datapath.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_r <= 1'b0;
      id_r       <= '0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        id_r <= grant_id_s;
      end
    end
  end

  // Result FIFO storage and pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_mem_r[0] <= '0;
      fifo_mem_r[1] <= '0;
      rd_ptr_r      <= 1'b0;
      wr_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= push_entry_s;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  // Outputs come straight from FIFO state, so they hold while stalled.
  always_comb begin
    resp_valid = (count_r != 2'd0);
    resp_data  = head_s.data;
    resp_id    = IDW'(head_s.id);
    busy       = inflight_r | (count_r != 2'd0);
  end

endmodule

// File: tb/tb_bfxp_arbiter.sv
// Directed self-checking bench for bfxp_arbiter (NREQ=2): single ops,
// alternation, back-pressure and asynchronous reset mid-operation.
module tb_bfxp_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_rs1;
  logic [63:0] req_rs2;
  logic [9:0]  req_start;
  logic [9:0]  req_len;
  logic [9:0]  req_dest;
  logic [1:0]  req_bfxpc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [0:0]  resp_id;
  logic        busy;

  int          checks;
  int          errors;
  logic [31:0] qd [$];
  logic        qi [$];
  logic        exp_next;
  logic [31:0] tagd [2];
  logic [4:0]  stall_acc;

  bfxp_arbiter #(.NREQ(2), .IDW(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_start  (req_start),
    .req_len    (req_len),
    .req_dest   (req_dest),
    .req_bfxpc  (req_bfxpc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] st, input logic [4:0] ln, input logic [4:0] ds,
                        input logic cpl);
    req_rs1[32*i +: 32] = rs1;
    req_rs2[32*i +: 32] = rs2;
    req_start[5*i +: 5] = st;
    req_len[5*i +: 5]   = ln;
    req_dest[5*i +: 5]  = ds;
    req_bfxpc[i]        = cpl;
  endtask

  // One isolated operation with the consumer always ready.
  task automatic single_op(input int i, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [4:0] st, input logic [4:0] ln, input logic [4:0] ds,
                           input logic cpl, input logic [31:0] exp);
    logic [1:0] oh;
    oh = 2'b01 << i;
    set_op(i, rs1, rs2, st, ln, ds, cpl);
    req_valid = oh;
    #1;
    check("single_ready", 32'(req_ready), 32'(oh));
    @(negedge clock);
    req_valid = 2'b00;
    #1;
    check("single_lat1_valid", 32'(resp_valid), 32'd0);
    @(negedge clock);
    #1;
    check("single_lat2_valid", 32'(resp_valid), 32'd1);
    check("single_data", resp_data, exp);
    check("single_id", 32'(resp_id), 32'(i));
    @(negedge clock);
    #1;
    check("single_after_valid", 32'(resp_valid), 32'd0);
    check("single_after_busy", 32'(busy), 32'd0);
  endtask

  // One cycle of streaming: check grant, scoreboard the head result.
  task automatic step(input logic acc);
    logic [1:0] e;
    e = acc ? (2'b01 << exp_next) : 2'b00;
    #1;
    check("grant", 32'(req_ready), 32'(e));
    if (acc) begin
      qd.push_back(tagd[exp_next]);
      qi.push_back(exp_next);
      exp_next = ~exp_next;
    end
    if (resp_valid) begin
      if (qd.size() == 0) begin
        check("resp_spurious", 32'(resp_valid), 32'd0);
      end else begin
        check("resp_data", resp_data, qd[0]);
        check("resp_id", 32'(resp_id), 32'(qi[0]));
        if (resp_ready) begin
          void'(qd.pop_front());
          void'(qi.pop_front());
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (busy || qd.size() != 0); n++) begin
      step(1'b0);
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_empty", 32'(qd.size()), 32'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    req_valid  = 2'b11;
    req_rs1    = '0;
    req_rs2    = '0;
    req_start  = '0;
    req_len    = '0;
    req_dest   = '0;
    req_bfxpc  = '0;
    resp_ready = 1'b1;
    exp_next   = 1'b0;
    tagd[0]    = 32'hA0A0_A0A0;
    tagd[1]    = 32'hB1B1_B1B1;

    @(negedge clock);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    req_valid = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    single_op(0, 32'h0000_ABCD, 32'hFFFF_FFFF, 5'd4, 5'd8, 5'd16, 1'b0, 32'hFFBC_FFFF);
    single_op(1, 32'h0000_ABCD, 32'hFFFF_FFFF, 5'd4, 5'd8, 5'd16, 1'b1, 32'hFF43_FFFF);
    single_op(0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7, 5'd0, 5'd3, 1'b0, 32'h1234_5678);
    single_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 5'd0, 5'd8, 5'd28, 1'b0, 32'hF000_0000);

    // Last grant was requester 0, so requester 1 wins first.
    set_op(0, 32'h1111_1111, tagd[0], 5'd0, 5'd0, 5'd0, 1'b0);
    set_op(1, 32'h2222_2222, tagd[1], 5'd0, 5'd0, 5'd0, 1'b0);
    exp_next  = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) step(1'b1);
    req_valid = 2'b00;
    drain();

    resp_ready = 1'b0;
    req_valid  = 2'b11;
    stall_acc  = 5'b00011;
    for (int k = 0; k < 5; k++) step(stall_acc[k]);
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) step(1'b1);
    req_valid = 2'b00;
    drain();

    resp_ready = 1'b0;
    req_valid  = 2'b11;
    step(1'b1);
    step(1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    qd.delete();
    qi.delete();
    resp_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    exp_next  = 1'b0;
    req_valid = 2'b11;
    step(1'b1);
    req_valid = 2'b00;
    drain();
    single_op(1, 32'h8000_0001, 32'h0000_0000, 5'd31, 5'd1, 5'd0, 1'b0, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
